// File: rtl/uart_32_bit_tx_fifo_if.sv
// Handshake and status bundle between the UART TX word FIFO and its surroundings.
// The register interface and the transmitter share the master side; the FIFO is the slave.
interface uart_32_bit_tx_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  flush;
  logic                  clr_overflow;
  logic                  tx_ready;
  logic                  tx_valid;
  logic [DATA_WIDTH-1:0] tx_data;
  logic [ADDR_WIDTH:0]   count;
  logic                  empty;
  logic                  full;
  logic                  afull;
  logic                  overflow;

  modport slave (
    input  wr_en, wr_data, flush, clr_overflow, tx_ready,
    output tx_valid, tx_data, count, empty, full, afull, overflow
  );

  modport master (
    output wr_en, wr_data, flush, clr_overflow, tx_ready,
    input  tx_valid, tx_data, count, empty, full, afull, overflow
  );
endinterface

// File: rtl/uart_32_bit_tx_fifo.sv
// First-word-fall-through word FIFO feeding the 32-bit UART transmitter.
// Status flags decode the registered occupancy only, so no input reaches an output combinationally.
module uart_32_bit_tx_fifo #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 8,
  parameter int ADDR_WIDTH  = $clog2(DEPTH),
  parameter int AFULL_LEVEL = 6
) (
  input logic                   clk,
  input logic                   rst,
  uart_32_bit_tx_fifo_if.slave  bus
);

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_FULL  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_AFULL = (ADDR_WIDTH+1)'(AFULL_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  push, pop, drop, mem_we;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    pop        = (count_q != '0) & bus.tx_ready;
    push       = bus.wr_en & ((count_q != CNT_FULL) | pop);
    drop       = bus.wr_en & (count_q == CNT_FULL) & ~pop;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    mem_we     = 1'b0;

    // Flush wins over any simultaneous push or pop.
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end

    // Sticky flag: a dropped word beats a simultaneous clear; flush leaves it alone.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (bus.clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: storage is deliberately not reset; contents are only meaningful behind a valid count.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  assign bus.tx_data  = mem_q[rd_ptr_q];
  assign bus.tx_valid = (count_q != '0);
  assign bus.empty    = (count_q == '0);
  assign bus.full     = (count_q == CNT_FULL);
  assign bus.afull    = (count_q >= CNT_AFULL);
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_uart_32_bit_tx_fifo.sv
// Scoreboard bench for the UART TX word FIFO: stimulus queues expected words,
// a negedge monitor pops and compares every accepted transfer.
`timescale 1ns/1ps
module tb_uart_32_bit_tx_fifo;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_32_bit_tx_fifo_if #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) bus ();

  uart_32_bit_tx_fifo #(
    .DATA_WIDTH(32), .DEPTH(8), .ADDR_WIDTH(3), .AFULL_LEVEL(6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb[$];
  int          mcount = 0;
  logic        mov = 1'b0;
  logic        last_push;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // One clock of stimulus; the occupancy/overflow model runs on pre-edge state.
  task automatic cycle(input logic r, input logic we, input logic [31:0] d,
                       input logic rdy, input logic fl, input logic clr);
    logic pop_m, push_m, drop_m;
    rst              = r;
    bus.wr_en        = we;
    bus.wr_data      = d;
    bus.tx_ready     = rdy;
    bus.flush        = fl;
    bus.clr_overflow = clr;
    pop_m  = (mcount != 0) && rdy;
    push_m = we && ((mcount != 8) || pop_m);
    drop_m = we && (mcount == 8) && !pop_m;
    if (r) begin
      sb.delete();
      mcount = 0;
      mov    = 1'b0;
    end else begin
      if (fl) begin
        sb.delete();
        mcount = 0;
      end else begin
        if (push_m) sb.push_back(d);
        mcount = mcount + int'(push_m) - int'(pop_m);
      end
      if (drop_m) mov = 1'b1;
      else if (clr) mov = 1'b0;
    end
    last_push = push_m && !r && !fl;
    @(posedge clk);
    #1;
    check("count", 32'(bus.count), mcount);
    check("overflow", 32'(bus.overflow), 32'(mov));
    check("empty", 32'(bus.empty), 32'(mcount == 0));
    check("full", 32'(bus.full), 32'(mcount == 8));
    check("tx_valid", 32'(bus.tx_valid), 32'(mcount != 0));
  endtask

  // Monitor: a transfer is valid & ready with neither reset nor flush overriding it.
  initial begin
    logic [31:0] exp_w;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && bus.flush === 1'b0 && bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop act=%h exp=none", bus.tx_data);
        end else begin
          exp_w = sb.pop_front();
          check("tx_data", bus.tx_data, exp_w);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pushed;
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_data = '0; bus.tx_ready = 1'b0;
    bus.flush = 1'b0; bus.clr_overflow = 1'b0;

    // Reset and idle state
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    check("rst_empty", 32'(bus.empty), 1);
    check("rst_valid", 32'(bus.tx_valid), 0);
    check("rst_afull", 32'(bus.afull), 0);

    // Fill 0x11111111..0x88888888 with the transmitter stalled
    for (int k = 1; k <= 8; k++) begin
      cycle(0, 1, 32'h1111_1111 * k, 0, 0, 0);
      if (k == 5) check("afull_at5", 32'(bus.afull), 0);
      if (k == 6) begin
        check("afull_at6", 32'(bus.afull), 1);
        check("count_at6", 32'(bus.count), 6);
      end
    end
    check("full_at8", 32'(bus.full), 1);
    check("head_fill", bus.tx_data, 32'h1111_1111);

    // Dropped push, set-beats-clear, then clear
    cycle(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
    check("ovf_set", 32'(bus.overflow), 1);
    check("ovf_count", 32'(bus.count), 8);
    check("ovf_head", bus.tx_data, 32'h1111_1111);
    cycle(0, 1, 32'hDEAD_BEEF, 0, 0, 1);
    check("ovf_set_wins", 32'(bus.overflow), 1);
    cycle(0, 0, 0, 0, 0, 1);
    check("ovf_clr", 32'(bus.overflow), 0);

    // Full + push + pop in the same cycle
    cycle(0, 1, 32'hCAFE_F00D, 1, 0, 0);
    check("simul_count", 32'(bus.count), 8);
    check("simul_ovf", 32'(bus.overflow), 0);
    check("simul_head", bus.tx_data, 32'h2222_2222);
    for (int k = 0; k < 8; k++) cycle(0, 0, 0, 1, 0, 0);
    check("drained_empty", 32'(bus.empty), 1);

    // Ready while empty, then empty + push + ready
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 1, 32'h1234_5678, 1, 0, 0);
    check("e2ne_count", 32'(bus.count), 1);
    check("e2ne_valid", 32'(bus.tx_valid), 1);
    check("e2ne_data", bus.tx_data, 32'h1234_5678);

    // Head stays stable under backpressure
    cycle(0, 1, 32'h9ABC_DEF0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    check("stall_head", bus.tx_data, 32'h1234_5678);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);

    // Wrap: 20 words with random push and ready stalls
    pushed = 0;
    for (int c = 0; c < 400 && (pushed < 20 || mcount > 0); c++) begin
      cycle(0, (pushed < 20) && ($urandom_range(0, 3) != 0), 32'hA500_0000 + pushed,
            1'($urandom_range(0, 1)), 0, 0);
      if (last_push) pushed++;
    end
    check("wrap_pushed", pushed, 20);
    check("wrap_drained", mcount, 0);

    // Flush with 5 words stored and overflow set
    for (int k = 0; k < 8; k++) cycle(0, 1, 32'hF000_0000 + k, 0, 0, 0);
    cycle(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1, 0, 0);
    check("pre_flush_count", 32'(bus.count), 5);
    cycle(0, 1, 32'h0BAD_BAD0, 1, 1, 0);
    check("flush_count", 32'(bus.count), 0);
    check("flush_valid", 32'(bus.tx_valid), 0);
    check("flush_ovf", 32'(bus.overflow), 1);
    cycle(0, 1, 32'h600D_600D, 0, 0, 0);
    check("post_flush_head", bus.tx_data, 32'h600D_600D);

    // Reset held two cycles mid-traffic
    cycle(0, 1, 32'h0000_0002, 0, 0, 0);
    cycle(0, 1, 32'h0000_0003, 0, 0, 0);
    cycle(1, 1, 32'h0000_0004, 1, 0, 0);
    cycle(1, 1, 32'h0000_0005, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    check("rst2_count", 32'(bus.count), 0);
    check("rst2_empty", 32'(bus.empty), 1);
    check("rst2_valid", 32'(bus.tx_valid), 0);
    check("rst2_ovf", 32'(bus.overflow), 0);

    // Normal operation resumes after reset
    cycle(0, 1, 32'h5A5A_A5A5, 0, 0, 0);
    check("post_rst_head", bus.tx_data, 32'h5A5A_A5A5);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    check("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
